// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of the instruction-memory port, redirect port and IF/ID handshake
// seen by the fetch sequencer (master) and its environment (slave).
interface imem_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        halted;
  logic        fault;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output id_valid,
    output id_pc,
    output id_instr,
    output halted,
    output fault
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    output id_ready,
    input  id_valid,
    input  id_pc,
    input  id_instr,
    input  halted,
    input  fault
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: walks the fetch PC through a combinational-read
// instruction memory and queues {pc, instr} pairs for the IF/ID stage.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_BYTES = 84,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic               clk,
  input  logic               reset,
  imem_fetch_ctrl_if.master  bus
);

  localparam int unsigned   PW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned   CW      = $clog2(QDEPTH + 1);
  localparam logic [31:0]   LAST_PC = 32'(IMEM_BYTES - 4);
  localparam logic [CW-1:0] FULL    = CW'(QDEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_next;
  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;
  logic          flush;
  logic          halted_q;
  logic          fault_q;

  // A head entry leaves only when the IF/ID stage takes it.
  assign pop = (count != {CW{1'b0}}) && bus.id_ready;

  // Next-state and fetch decision; a redirect outranks everything outside FAULT.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    push          = 1'b0;
    flush         = 1'b0;
    if (bus.redirect_valid && (state != ST_FAULT)) begin
      flush = 1'b1;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        state_next = ST_FAULT;
      end else begin
        fetch_pc_next = bus.redirect_pc;
        state_next    = ST_RUN;
      end
    end else if (state == ST_RUN) begin
      if (fetch_pc > LAST_PC) begin
        // Only reachable after a redirect past the end of memory.
        state_next = ST_HALT;
      end else if ((count != FULL) || pop) begin
        push = 1'b1;
        if (fetch_pc == LAST_PC) begin
          state_next = ST_HALT;
        end else begin
          fetch_pc_next = fetch_pc + 32'd4;
        end
      end else begin
        fetch_pc_next = fetch_pc;
      end
    end else begin
      state_next = state;
    end
  end

  // State, fetch PC and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      fetch_pc <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      halted_q <= (state_next == ST_HALT);
      fault_q  <= (state_next == ST_FAULT);
    end
  end

  // Fetch queue: circular buffer whose pointers wrap naturally at QDEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= {PW{1'b0}};
      wr_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]    <= 32'h0;
        q_instr[i] <= 32'h0;
      end
    end else if (flush) begin
      rd_ptr <= {PW{1'b0}};
      wr_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        q_pc[wr_ptr]    <= fetch_pc;
        q_instr[wr_ptr] <= bus.imem_rdata;
        wr_ptr          <= wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count <= count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count <= count - {{(CW-1){1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

  assign bus.imem_addr = fetch_pc;
  assign bus.id_valid  = (count != {CW{1'b0}});
  assign bus.id_pc     = q_pc[rd_ptr];
  assign bus.id_instr  = q_instr[rd_ptr];
  assign bus.halted    = halted_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed scenarios followed by a
// randomized phase, checked against a queue-based reference model.
module tb_imem_fetch_ctrl;

  localparam int          IMEM_BYTES = 84;
  localparam int          QDEPTH     = 2;
  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam logic [31:0] LAST       = 32'(IMEM_BYTES - 4);
  localparam int          S_RUN      = 0;
  localparam int          S_HALT     = 1;
  localparam int          S_FAULT    = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk;
  logic reset;
  imem_fetch_ctrl_if bus_if ();

  imem_fetch_ctrl #(
    .RESET_PC   (RESET_PC),
    .IMEM_BYTES (IMEM_BYTES),
    .QDEPTH     (QDEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
  );

  logic [7:0]  mem [IMEM_BYTES];
  ent_t        m_q[$];
  ent_t        sb[$];
  logic [31:0] m_pc;
  int          m_st;
  int          checks;
  int          errors;
  logic [31:0] last_pc;
  logic [31:0] last_instr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_word(input logic [31:0] a);
    if (a + 32'd3 < 32'(IMEM_BYTES))
      return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    return 32'h0;
  endfunction

  // Little-endian combinational instruction memory
  always_comb begin
    if (bus_if.imem_addr + 32'd3 < 32'(IMEM_BYTES))
      bus_if.imem_rdata = {mem[bus_if.imem_addr+3], mem[bus_if.imem_addr+2],
                           mem[bus_if.imem_addr+1], mem[bus_if.imem_addr]};
    else
      bus_if.imem_rdata = 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction-level step per clock
  always @(posedge clk or posedge reset) begin
    int   cnt;
    logic pop;
    ent_t e;
    if (reset) begin
      m_q.delete();
      sb.delete();
      m_pc <= RESET_PC;
      m_st <= S_RUN;
    end else begin
      cnt = m_q.size();
      pop = (cnt != 0) && bus_if.id_ready;
      if (bus_if.redirect_valid && m_st != S_FAULT) begin
        m_q.delete();
        sb.delete();
        if (bus_if.redirect_pc[1:0] != 2'b00) begin
          m_st <= S_FAULT;
        end else begin
          m_pc <= bus_if.redirect_pc;
          m_st <= S_RUN;
        end
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_st == S_RUN) begin
          if (m_pc > LAST) begin
            m_st <= S_HALT;
          end else if (cnt < QDEPTH || pop) begin
            e.pc    = m_pc;
            e.instr = m_word(m_pc);
            m_q.push_back(e);
            sb.push_back(e);
            if (m_pc == LAST) m_st <= S_HALT;
            else              m_pc <= m_pc + 32'd4;
          end
        end
      end
    end
  end

  // Monitor: compares status each cycle and every accepted entry against the scoreboard
  always @(negedge clk) begin
    ent_t e;
    chk("id_valid", {31'b0, bus_if.id_valid}, {31'b0, m_q.size() != 0});
    chk("imem_addr", bus_if.imem_addr, m_pc);
    chk("halted", {31'b0, bus_if.halted}, {31'b0, m_st == S_HALT});
    chk("fault", {31'b0, bus_if.fault}, {31'b0, m_st == S_FAULT});
    if (bus_if.id_valid && bus_if.id_ready && !reset) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got pc %h with nothing expected at %0t", bus_if.id_pc, $time);
      end else begin
        e = sb.pop_front();
        chk("id_pc", bus_if.id_pc, e.pc);
        chk("id_instr", bus_if.id_instr, e.instr);
        last_pc    = bus_if.id_pc;
        last_instr = bus_if.id_instr;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus_if.redirect_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = pc;
    cyc();
    bus_if.redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    checks = 0;
    errors = 0;
    last_pc = 32'h0;
    last_instr = 32'h0;
    reset = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0;
    bus_if.id_ready       = 1'b0;
    for (int i = 0; i < IMEM_BYTES / 4; i++) begin
      w = 32'h00100093 + (32'(i) << 15) + 32'(i * 7);
      if (i == 0 || i == 7) w = 32'h00000B13;
      if (i == 20)          w = 32'h7E558C63;
      for (int b = 0; b < 4; b++) mem[4*i+b] = w[8*b +: 8];
    end

    // Reset state
    do_reset();
    chk("rst_id_valid", {31'b0, bus_if.id_valid}, 32'h0);
    chk("rst_id_pc", bus_if.id_pc, 32'h0);
    chk("rst_id_instr", bus_if.id_instr, 32'h0);
    chk("rst_imem_addr", bus_if.imem_addr, RESET_PC);
    chk("rst_halted", {31'b0, bus_if.halted}, 32'h0);
    chk("rst_fault", {31'b0, bus_if.fault}, 32'h0);

    // 1) streaming from reset, first entry in cycle 1
    bus_if.id_ready = 1'b1;
    cyc();
    chk("t1_first_valid", {31'b0, bus_if.id_valid}, 32'h1);
    chk("t1_first_pc", bus_if.id_pc, 32'h0);
    chk("t1_first_instr", bus_if.id_instr, 32'h00000B13);
    cyc();
    chk("t1_second_pc", bus_if.id_pc, 32'h4);
    repeat (4) cyc();

    // 2) stall with full queue, then drain in order
    do_reset();
    bus_if.id_ready = 1'b0;
    repeat (5) cyc();
    chk("t2_stall_addr", bus_if.imem_addr, 32'h8);
    chk("t2_stall_head", bus_if.id_pc, 32'h0);
    bus_if.id_ready = 1'b1;
    cyc();
    chk("t2_next_head", bus_if.id_pc, 32'h4);
    repeat (4) cyc();

    // 3) redirect flushes the queue
    do_reset();
    bus_if.id_ready = 1'b1;
    repeat (5) cyc();
    chk("t3_head_before", bus_if.id_pc, 32'h10);
    redirect(32'h1C);
    chk("t3_flushed", {31'b0, bus_if.id_valid}, 32'h0);
    cyc();
    chk("t3_target_pc", bus_if.id_pc, 32'h1C);
    chk("t3_target_instr", bus_if.id_instr, 32'h00000B13);

    // 4) run to the end of memory, then restart from HALT
    do_reset();
    bus_if.id_ready = 1'b1;
    repeat (26) cyc();
    chk("t4_halted", {31'b0, bus_if.halted}, 32'h1);
    chk("t4_last_pc", last_pc, 32'h50);
    chk("t4_last_instr", last_instr, 32'h7E558C63);
    redirect(32'h0);
    chk("t4_resume_halted", {31'b0, bus_if.halted}, 32'h0);
    cyc();
    chk("t4_resume_pc", bus_if.id_pc, 32'h0);

    // 5) misaligned target faults; later redirects ignored; reset clears
    do_reset();
    bus_if.id_ready = 1'b0;
    repeat (3) cyc();
    redirect(32'h6);
    chk("t5_fault", {31'b0, bus_if.fault}, 32'h1);
    redirect(32'h0);
    chk("t5_fault_sticky", {31'b0, bus_if.fault}, 32'h1);
    chk("t5_pc_frozen", bus_if.imem_addr, 32'h8);
    do_reset();
    chk("t5_fault_cleared", {31'b0, bus_if.fault}, 32'h0);

    // 6) asynchronous reset mid-cycle with two entries queued
    bus_if.id_ready = 1'b0;
    repeat (3) cyc();
    chk("t6_queued", {31'b0, bus_if.id_valid}, 32'h1);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", {31'b0, bus_if.id_valid}, 32'h0);
    chk("t6_async_addr", bus_if.imem_addr, RESET_PC);
    cyc();
    reset = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus_if.id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) begin
        bus_if.redirect_valid = 1'b1;
        if ($urandom_range(0, 7) == 0)
          bus_if.redirect_pc = 32'($urandom_range(0, 20) * 4 + $urandom_range(1, 3));
        else
          bus_if.redirect_pc = 32'($urandom_range(0, 23) * 4);
      end else begin
        bus_if.redirect_valid = 1'b0;
      end
      cyc();
    end
    reset = 1'b0;
    bus_if.redirect_valid = 1'b0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
